// File: rtl/tqvp_reg_arbiter.sv
// tqvp_reg_arbiter
// Shares one 4-bit-address / 8-bit-data peripheral register port between two
// requesters (A: SPI register bridge, B: sample sequencer). Round-robin between
// simultaneous requests, with an optional lock that lets the current owner keep
// the port for up to MAX_BURST back-to-back accesses.
module tqvp_reg_arbiter #(
  parameter int READ_WAIT = 0,
  parameter int MAX_BURST = 4
) (
  input  logic       clk,
  input  logic       rst_n,

  input  logic       a_req,
  input  logic       a_we,
  input  logic [3:0] a_addr,
  input  logic [7:0] a_wdata,
  input  logic       a_lock,
  output logic       a_ack,
  output logic [7:0] a_rdata,

  input  logic       b_req,
  input  logic       b_we,
  input  logic [3:0] b_addr,
  input  logic [7:0] b_wdata,
  input  logic       b_lock,
  output logic       b_ack,
  output logic [7:0] b_rdata,

  output logic [3:0] p_address,
  output logic [7:0] p_data_in,
  output logic       p_data_write,
  input  logic [7:0] p_data_out
);

  localparam int WCW = (READ_WAIT > 1) ? $clog2(READ_WAIT) : 1;
  localparam int BCW = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
  localparam logic [WCW-1:0] WAIT_LAST  = WCW'((READ_WAIT > 0) ? READ_WAIT - 1 : 0);
  localparam logic [BCW-1:0] BURST_LAST = BCW'(MAX_BURST - 1);
  localparam bit HAS_WAIT = (READ_WAIT > 0);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    WAIT   = 2'd2,
    ACK    = 2'd3
  } state_t;

  state_t         state;
  logic           owner;       // 0 = A, 1 = B
  logic           rr_ptr;      // side that wins the next simultaneous request
  logic           owner_we;
  logic           prev_lock;   // owner's lock as seen during its ack cycle
  logic [BCW-1:0] burst_cnt;
  logic [WCW-1:0] wait_cnt;

  logic       owner_req;
  logic       owner_lock;
  logic       regrant;
  logic       grant_valid;
  logic       grant_side;
  logic       sel_we;
  logic [3:0] sel_addr;
  logic [7:0] sel_wdata;
  logic       access_done;

  // Arbitration decision and selection of the winning requester's fields
  always_comb begin
    owner_req   = owner ? b_req  : a_req;
    owner_lock  = owner ? b_lock : a_lock;
    regrant     = prev_lock && owner_req && (burst_cnt < BURST_LAST);
    grant_valid = regrant || a_req || b_req;
    grant_side  = 1'b0;
    if (regrant) begin
      grant_side = owner;
    end else if (a_req && b_req) begin
      grant_side = rr_ptr;
    end else if (b_req) begin
      grant_side = 1'b1;
    end
    sel_we    = grant_side ? b_we    : a_we;
    sel_addr  = grant_side ? b_addr  : a_addr;
    sel_wdata = grant_side ? b_wdata : a_wdata;
    access_done = ((state == ACCESS) && (owner_we || !HAS_WAIT)) ||
                  ((state == WAIT) && (wait_cnt == WAIT_LAST));
  end

  // Access sequencer: grant, drive the peripheral, capture read data, pulse ack
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      owner        <= 1'b0;
      rr_ptr       <= 1'b0;
      owner_we     <= 1'b0;
      prev_lock    <= 1'b0;
      burst_cnt    <= '0;
      wait_cnt     <= '0;
      p_address    <= 4'd0;
      p_data_in    <= 8'd0;
      p_data_write <= 1'b0;
      a_ack        <= 1'b0;
      b_ack        <= 1'b0;
      a_rdata      <= 8'd0;
      b_rdata      <= 8'd0;
    end else begin
      case (state)
        IDLE: begin
          prev_lock <= 1'b0;
          if (grant_valid) begin
            owner        <= grant_side;
            owner_we     <= sel_we;
            p_address    <= sel_addr;
            p_data_in    <= sel_wdata;
            p_data_write <= sel_we;
            wait_cnt     <= '0;
            state        <= ACCESS;
            if (regrant) begin
              burst_cnt <= burst_cnt + BCW'(1);
            end else begin
              burst_cnt <= '0;
              rr_ptr    <= ~grant_side;
            end
          end
        end
        ACCESS: begin
          p_data_write <= 1'b0;
          if (!access_done) begin
            state <= WAIT;
          end
        end
        WAIT: begin
          if (!access_done) begin
            wait_cnt <= wait_cnt + WCW'(1);
          end
        end
        ACK: begin
          a_ack     <= 1'b0;
          b_ack     <= 1'b0;
          prev_lock <= owner_lock;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase

      if (access_done) begin
        state <= ACK;
        if (owner) begin
          b_ack   <= 1'b1;
          b_rdata <= p_data_out;
        end else begin
          a_ack   <= 1'b1;
          a_rdata <= p_data_out;
        end
      end
    end
  end

endmodule

// File: tb/tb_tqvp_reg_arbiter.sv
// tb_tqvp_reg_arbiter
// Scoreboard bench: stimulus pushes expected acks and write strobes into queues,
// a negedge monitor pops and compares them as the arbiter presents them.
module tb_tqvp_reg_arbiter;

  logic       clk;
  logic       rst_n;
  logic       a_req, a_we, a_lock, a_ack;
  logic [3:0] a_addr;
  logic [7:0] a_wdata, a_rdata;
  logic       b_req, b_we, b_lock, b_ack;
  logic [3:0] b_addr;
  logic [7:0] b_wdata, b_rdata;
  logic [3:0] p_address;
  logic [7:0] p_data_in;
  logic       p_data_write;
  logic [7:0] p_data_out;

  typedef struct packed {
    logic       side;
    logic       we;
    logic [7:0] rdata;
  } exp_t;

  exp_t        exp_q[$];
  logic [11:0] wr_q[$];
  exp_t        mon_e;
  logic [11:0] mon_w;
  logic        prev_pdw;

  int checks = 0;
  int passes = 0;

  tqvp_reg_arbiter #(.READ_WAIT(2), .MAX_BURST(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
    .a_lock(a_lock), .a_ack(a_ack), .a_rdata(a_rdata),
    .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
    .b_lock(b_lock), .b_ack(b_ack), .b_rdata(b_rdata),
    .p_address(p_address), .p_data_in(p_data_in),
    .p_data_write(p_data_write), .p_data_out(p_data_out)
  );

  // Read-only peripheral model: address 7 returns 0xC3, others {~addr, addr}
  assign p_data_out = (p_address == 4'd7) ? 8'hC3 : {~p_address, p_address};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual === expected) passes++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
  endtask

  task automatic applyStimulus(input logic side, input logic we, input logic [3:0] addr,
                               input logic [7:0] wdata, input logic lock);
    if (side) begin
      b_req = 1'b1; b_we = we; b_addr = addr; b_wdata = wdata; b_lock = lock;
    end else begin
      a_req = 1'b1; a_we = we; a_addr = addr; a_wdata = wdata; a_lock = lock;
    end
  endtask

  task automatic expectAck(input logic side, input logic we, input logic [7:0] rdata);
    exp_t e;
    e.side = side; e.we = we; e.rdata = rdata;
    exp_q.push_back(e);
  endtask

  task automatic expectWrite(input logic [3:0] addr, input logic [7:0] data);
    wr_q.push_back({addr, data});
  endtask

  task automatic clearInputs();
    a_req = 0; a_we = 0; a_addr = 0; a_wdata = 0; a_lock = 0;
    b_req = 0; b_we = 0; b_addr = 0; b_wdata = 0; b_lock = 0;
  endtask

  task automatic doReset();
    rst_n = 1'b0;
    clearInputs();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  // Starts at cycle 0 of a stream of back-to-back grants; acks must fall on
  // every third cycle, and all requests are dropped once nacks have been seen
  task automatic runSlots(input int nacks);
    int acks = 0;
    for (int cyc = 0; cyc < nacks * 3 + 3; cyc++) begin
      @(negedge clk);
      checkOutput("ack_slot", {31'd0, a_ack | b_ack},
                  {31'd0, (cyc % 3 == 2) && (cyc < nacks * 3)});
      if (a_ack || b_ack) begin
        acks++;
        if (acks == nacks) begin
          a_req = 0; b_req = 0; a_lock = 0; b_lock = 0;
        end
      end
    end
  endtask

  // Monitor: pops the scoreboards whenever an ack or a write strobe appears
  initial begin
    prev_pdw = 1'b0;
    forever begin
      @(negedge clk);
      if (a_ack || b_ack) begin
        checkOutput("ack_exclusive", {31'd0, a_ack && b_ack}, 32'd0);
        checkOutput("ack_expected", {31'd0, exp_q.size() > 0}, 32'd1);
        if (exp_q.size() > 0) begin
          mon_e = exp_q.pop_front();
          checkOutput("ack_side", {31'd0, b_ack}, {31'd0, mon_e.side});
          if (!mon_e.we)
            checkOutput("rdata", {24'd0, mon_e.side ? b_rdata : a_rdata}, {24'd0, mon_e.rdata});
        end
      end
      if (p_data_write) begin
        checkOutput("strobe_single_cycle", {31'd0, prev_pdw}, 32'd0);
        checkOutput("write_expected", {31'd0, wr_q.size() > 0}, 32'd1);
        if (wr_q.size() > 0) begin
          mon_w = wr_q.pop_front();
          checkOutput("write_addr", {28'd0, p_address}, {28'd0, mon_w[11:8]});
          checkOutput("write_data", {24'd0, p_data_in}, {24'd0, mon_w[7:0]});
        end
      end
      prev_pdw = p_data_write;
    end
  end

  initial begin
    rst_n = 1'b0;
    clearInputs();

    // Reset state
    repeat (2) @(negedge clk);
    checkOutput("reset_a_ack", {31'd0, a_ack}, 32'd0);
    checkOutput("reset_b_ack", {31'd0, b_ack}, 32'd0);
    checkOutput("reset_a_rdata", {24'd0, a_rdata}, 32'd0);
    checkOutput("reset_b_rdata", {24'd0, b_rdata}, 32'd0);
    checkOutput("reset_p_address", {28'd0, p_address}, 32'd0);
    checkOutput("reset_p_data_in", {24'd0, p_data_in}, 32'd0);
    checkOutput("reset_p_data_write", {31'd0, p_data_write}, 32'd0);
    @(posedge clk); #1 rst_n = 1'b1;
    @(posedge clk); #1;

    // Test 1: lone A write
    $display("[TB] test 1: A write");
    applyStimulus(0, 1, 4'd3, 8'h5A, 0);
    expectAck(0, 1, 8'h00);
    expectWrite(4'd3, 8'h5A);
    @(negedge clk);
    checkOutput("t1_c0_strobe", {31'd0, p_data_write}, 32'd0);
    @(negedge clk);
    checkOutput("t1_c1_strobe", {31'd0, p_data_write}, 32'd1);
    checkOutput("t1_c1_addr", {28'd0, p_address}, 32'd3);
    checkOutput("t1_c1_data", {24'd0, p_data_in}, 32'h5A);
    checkOutput("t1_c1_a_ack", {31'd0, a_ack}, 32'd0);
    @(negedge clk);
    checkOutput("t1_c2_a_ack", {31'd0, a_ack}, 32'd1);
    checkOutput("t1_c2_b_ack", {31'd0, b_ack}, 32'd0);
    checkOutput("t1_c2_strobe", {31'd0, p_data_write}, 32'd0);
    a_req = 1'b0;
    @(negedge clk);
    checkOutput("t1_c3_a_ack", {31'd0, a_ack}, 32'd0);
    checkOutput("t1_c3_addr_held", {28'd0, p_address}, 32'd3);

    // Test 2: B read with two wait cycles
    @(posedge clk); #1;
    $display("[TB] test 2: B read with wait states");
    applyStimulus(1, 0, 4'd7, 8'h00, 0);
    expectAck(1, 0, 8'hC3);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      checkOutput("t2_no_strobe", {31'd0, p_data_write}, 32'd0);
      if (c >= 1 && c <= 3) begin
        checkOutput("t2_addr", {28'd0, p_address}, 32'd7);
        checkOutput("t2_b_ack_low", {31'd0, b_ack}, 32'd0);
      end
      if (c == 4) begin
        checkOutput("t2_b_ack", {31'd0, b_ack}, 32'd1);
        checkOutput("t2_b_rdata", {24'd0, b_rdata}, 32'hC3);
        checkOutput("t2_a_ack", {31'd0, a_ack}, 32'd0);
        b_req = 1'b0;
      end
    end

    // Test 3: simultaneous requests alternate A,B,A,B
    $display("[TB] test 3: round robin");
    doReset();
    applyStimulus(0, 1, 4'd1, 8'h11, 0);
    applyStimulus(1, 1, 4'd2, 8'h22, 0);
    for (int i = 0; i < 4; i++) begin
      expectAck(i[0], 1, 8'h00);
      if (i[0]) expectWrite(4'd2, 8'h22);
      else expectWrite(4'd1, 8'h11);
    end
    runSlots(4);

    // Test 4: locked A gets four back-to-back grants, then B, then A
    @(posedge clk); #1;
    $display("[TB] test 4: locked burst");
    doReset();
    applyStimulus(0, 1, 4'd4, 8'h44, 1);
    applyStimulus(1, 1, 4'd5, 8'h55, 0);
    for (int i = 0; i < 6; i++) begin
      expectAck(i == 4, 1, 8'h00);
      if (i == 4) expectWrite(4'd5, 8'h55);
      else expectWrite(4'd4, 8'h44);
    end
    runSlots(6);

    // Test 5: reset during a write access
    @(posedge clk); #1;
    $display("[TB] test 5: reset mid-access");
    doReset();
    applyStimulus(0, 1, 4'd9, 8'h99, 0);
    expectWrite(4'd9, 8'h99);
    @(negedge clk);
    @(negedge clk);
    checkOutput("t5_strobe_before", {31'd0, p_data_write}, 32'd1);
    #1 rst_n = 1'b0;
    #1 checkOutput("t5_strobe_async_drop", {31'd0, p_data_write}, 32'd0);
    a_req = 1'b0;
    repeat (2) begin
      @(negedge clk);
      checkOutput("t5_no_a_ack", {31'd0, a_ack}, 32'd0);
      checkOutput("t5_no_b_ack", {31'd0, b_ack}, 32'd0);
    end
    @(posedge clk); #1 rst_n = 1'b1;
    applyStimulus(0, 1, 4'hA, 8'hAA, 0);
    applyStimulus(1, 1, 4'hB, 8'hBB, 0);
    expectAck(0, 1, 8'h00);
    expectWrite(4'hA, 8'hAA);
    @(negedge clk);
    @(negedge clk);
    checkOutput("t5_first_grant_addr", {28'd0, p_address}, 32'hA);
    @(negedge clk);
    checkOutput("t5_a_ack", {31'd0, a_ack}, 32'd1);
    checkOutput("t5_b_ack", {31'd0, b_ack}, 32'd0);
    a_req = 1'b0; b_req = 1'b0;
    @(negedge clk);
    checkOutput("t5_idle_b_ack", {31'd0, b_ack}, 32'd0);
    checkOutput("t5_idle_strobe", {31'd0, p_data_write}, 32'd0);

    // Test 6: A drops its request during ACCESS
    @(posedge clk); #1;
    $display("[TB] test 6: request dropped mid-access");
    applyStimulus(0, 1, 4'd6, 8'h66, 0);
    expectAck(0, 1, 8'h00);
    expectWrite(4'd6, 8'h66);
    @(posedge clk); #1 a_req = 1'b0;
    @(negedge clk);
    checkOutput("t6_strobe", {31'd0, p_data_write}, 32'd1);
    @(negedge clk);
    checkOutput("t6_a_ack", {31'd0, a_ack}, 32'd1);
    repeat (4) begin
      @(negedge clk);
      checkOutput("t6_no_regrant_ack", {31'd0, a_ack}, 32'd0);
      checkOutput("t6_no_regrant_strobe", {31'd0, p_data_write}, 32'd0);
    end

    repeat (3) @(negedge clk);
    checkOutput("ack_queue_drained", exp_q.size(), 32'd0);
    checkOutput("write_queue_drained", wr_q.size(), 32'd0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
